// File: rtl/muldiv_unit_if.sv
// Issue/response bundle for muldiv_unit: request handshake, operands, flush and result.
// The issue stage holds the master modport and the unit holds the slave modport.
interface muldiv_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;

  modport master (
    output req_valid, op, operand_a, operand_b, flush, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, op, operand_a, operand_b, flush, resp_ready,
    output req_ready, resp_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with a fixed 33-cycle latency.
// Define MULDIV_DIV_EN to build the divider; without it, ops 4-7 return 0 with the same latency.
module muldiv_unit (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [5:0]  count_q;
  logic [2:0]  op_q;
  logic [31:0] opnd_q;    // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [63:0] acc_q;     // {partial product, multiplier} or {remainder, quotient}
  logic        sign_a_q;
  logic        sign_b_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] result_q;
`ifdef MULDIV_DIV_EN
  logic        b_zero_q;
`endif

  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] fin;

  // Operand signedness decode for the request being presented.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.op)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & bus.operand_a[31];
    b_neg = b_signed & bus.operand_b[31];
    a_mag = a_neg ? (~bus.operand_a + 32'd1) : bus.operand_a;
    b_mag = b_neg ? (~bus.operand_b + 32'd1) : bus.operand_b;
  end

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic [32:0] div_diff;

  // Restoring step: bit 32 of the difference is the borrow, since the shifted
  // remainder is always below twice the divisor.
  always_comb begin
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[32]) begin
        acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_step = {div_shift[31:0], acc_q[30:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
  end
`else
  always_comb begin
    acc_step = op_q[2] ? acc_q : {mul_sum, acc_q[31:1]};
  end
`endif

  // Sign correction and result selection, applied on the final BUSY cycle.
  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
    fin  = '0;
    case (op_q)
      3'd0:             fin = prod[31:0];
      3'd1, 3'd2, 3'd3: fin = prod[63:32];
      default: begin
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
          fin = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else if (b_zero_q) begin
          fin = '1;
        end else begin
          fin = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        end
`else
        fin = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      op_q         <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
`ifdef MULDIV_DIV_EN
      b_zero_q     <= 1'b0;
`endif
    end else if (bus.flush) begin
      state_q      <= StIdle;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q     <= StBusy;
            count_q     <= '0;
            op_q        <= bus.op;
            sign_a_q    <= a_neg;
            sign_b_q    <= b_neg;
            req_ready_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            b_zero_q    <= (bus.operand_b == 32'd0);
`endif
            if (bus.op[2]) begin
              opnd_q <= b_mag;
              acc_q  <= {32'd0, a_mag};
            end else begin
              opnd_q <= a_mag;
              acc_q  <= {32'd0, b_mag};
            end
          end
        end
        StBusy: begin
          if (count_q == 6'd32) begin
            state_q      <= StDone;
            resp_valid_q <= 1'b1;
            result_q     <= fin;
          end else begin
            acc_q   <= acc_step;
            count_q <= count_q + 6'd1;
          end
        end
        StDone: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency, plus
// backpressure, flush and reset sequences.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.exp  = (op[2] && !DivEn) ? 32'd0 : exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until resp_valid, bounded at 100.
  task automatic wait_resp(output logic [31:0] res, output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic watch_no_resp(input string name);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic        stable;
    int          lat;

    bus.req_valid  = 1'b0;
    bus.op         = 3'd0;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    rst            = 1'b1;

    add("mul_7_m3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    add("mulh_7_m3",       3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF);
    add("mulhu_max",       3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    add("mulhsu_max",      3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add("mul_shift",       3'd0, 32'h12345678, 32'h00000010, 32'h23456780);
    add("mulhu_shift",     3'd3, 32'h12345678, 32'h00000010, 32'h00000001);
    add("mulh_minsq",      3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    add("mulhsu_min_2",    3'd2, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
    add("mul_zero",        3'd0, 32'hDEADBEEF, 32'h00000000, 32'h00000000);
    add("div_m7_2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    add("rem_m7_2",        3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    add("divu_100_7",      3'd5, 32'd100,      32'd7,        32'd14);
    add("remu_100_7",      3'd7, 32'd100,      32'd7,        32'd2);
    add("div_7_m2",        3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
    add("rem_7_m2",        3'd6, 32'd7,        32'hFFFFFFFE, 32'd1);
    add("divu_by_zero",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF);
    add("rem_by_zero",     3'd6, 32'd5,        32'd0,        32'd5);
    add("div_neg_by_zero", 3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    add("rem_neg_by_zero", 3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    add("remu_by_zero",    3'd7, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    add("div_overflow",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    add("rem_overflow",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset_result",     bus.result,              32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_resp(res, lat);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, 32'd33);
      consume();
      check({vecs[i].name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
    end

    // Backpressure: result and req_ready must hold while DONE is stalled.
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_resp(res, lat);
    held   = bus.result;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.result !== held || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) begin
        stable = 1'b0;
      end
    end
    check("bp_result", held, 32'hFFFFFFEB);
    check("bp_stable", {31'd0, stable}, 32'd1);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("bp_ready_next",   {31'd0, bus.req_ready},  32'd1);
    check("bp_valid_cleared", {31'd0, bus.resp_valid}, 32'd0);
    check("bp_result_zero",  bus.result,              32'd0);
    watch_no_resp("bp_no_same_cycle_accept");

    // Flush at step 16 aborts the operation.
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (16) @(posedge clk);
    #1;
    check("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("busy_result",    bus.result,             32'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("flush_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    watch_no_resp("flush_no_resp");

    // Flush wins over a simultaneous request in IDLE.
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_prio_ready", {31'd0, bus.req_ready}, 32'd1);
    watch_no_resp("flush_prio_no_resp");

    // Reset at step 5 discards the operation.
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_result",    bus.result,             32'd0);
    watch_no_resp("rst_no_resp");

    // Unit still works after an abort.
    issue(3'd1, 32'd7, 32'hFFFFFFFD);
    wait_resp(res, lat);
    check("post_abort_mulh", res, 32'hFFFFFFFF);
    check("post_abort_latency", lat, 32'd33);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have a clk input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a rst input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have a req_valid input, 1 bit: the issue stage presents an operation.
REQ-004 The block SHALL have a req_ready output, 1 bit: high only in IDLE.
REQ-005 The block SHALL have an op input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have an operand_a input, 32 bits: multiplicand or dividend.
REQ-007 The block SHALL have an operand_b input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have a flush input, 1 bit: abort any in-flight operation.
REQ-009 The block SHALL have a resp_valid output, 1 bit: result is available.
REQ-010 The block SHALL have a resp_ready input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have a result output, 32 bits: the operation result.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 In IDLE, req_valid=1 SHALL capture op and both operands and enter BUSY with iteration count 0.
REQ-014 In BUSY, the block SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) and enter DONE after exactly 32 steps.
REQ-015 Latency SHALL be fixed: resp_valid rises on the 33rd rising edge after the accepting edge, regardless of operand values.
REQ-016 In DONE, resp_valid SHALL be 1 and result SHALL remain stable; resp_ready=1 SHALL return the FSM to IDLE on that edge.
REQ-017 A request SHALL NOT be accepted in the same cycle that a response is consumed; req_ready rises the cycle after.
REQ-018 Signed ops SHALL operate on operand magnitudes, with sign correction applied at the final step: MULH and DIV/REM use signed a and b, MULHSU uses signed a and unsigned b, and the rest are unsigned.
REQ-019 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the full 64-bit product.
REQ-020 REM SHALL take the sign of the dividend; DIV SHALL truncate toward zero.
REQ-021 For divide by zero, the quotient SHALL be 0xFFFFFFFF (DIV and DIVU) and the remainder SHALL be operand_a (REM and REMU); the full 33-cycle latency SHALL still apply.
REQ-022 For signed overflow (0x80000000 / 0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge with no resp_valid; flush has priority over req_valid and resp_ready.
REQ-024 result SHALL be 0 whenever resp_valid=0.

Reset
REQ-025 While rst=1, on each edge the FSM SHALL go to IDLE and the iteration counter and all datapath registers SHALL clear to 0.
REQ-026 After reset, req_ready SHALL be 1, resp_valid SHALL be 0 and result SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no response; rst has priority over flush.

Configuration
REQ-028 With macro MULDIV_DIV_EN defined, ops 4-7 SHALL be implemented as specified.
REQ-029 Without MULDIV_DIV_EN, the divide datapath SHALL be absent, and ops 4-7 SHALL complete with the same 33-cycle latency and return 0.

Verification
REQ-030 Test MUL: a=7, b=-3 (0xFFFFFFFD) -> after 33 cycles, result=0xFFFFFFEB and MULH result=0xFFFFFFFF.
REQ-031 Test MULHU: a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MULHSU with the same inputs -> result=0xFFFFFFFF.
REQ-032 Test DIV/REM: a=-7, b=2 -> DIV result=0xFFFFFFFD (-3) and REM result=0xFFFFFFFF (-1); DIVU with a=100, b=7 -> result=14.
REQ-033 Test boundaries: DIVU with a=5, b=0 -> 0xFFFFFFFF; REM with a=5, b=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-034 Test backpressure: hold resp_ready=0 for 10 cycles in DONE -> result stays stable and req_ready stays 0; then pulse resp_ready -> req_ready=1 on the next cycle.
REQ-035 Test abort: assert flush at BUSY step 16 -> IDLE next cycle and no resp_valid; assert rst at step 5 -> req_ready=1 and result=0 next cycle.
